segment_controller: RTL and testbench

SEGMENT_CONTROLLER -- requirements
Module: segment_controller

---
 rtl/segment_controller_if.sv | 22 ++
 rtl/segment_controller.sv | 138 +++++++++++++
 tb/tb_segment_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_controller_if.sv
// rtl/segment_controller_if.sv - SDRAM command and datapath modify handshake bundle
interface segment_controller_if #(
  parameter int ADDR_WID = 5
);
  logic [ADDR_WID-1:0] o_fragment_key;
  logic                o_cntl_s0_modify;
  logic                i_cntl_s0_modify_done;
  logic                o_sdram_read;
  logic                o_sdram_write;
  logic                i_sdram_waitrequest;
  logic                i_sdram_readdatavalid;

  modport master (
    output o_fragment_key, o_cntl_s0_modify, o_sdram_read, o_sdram_write,
    input  i_cntl_s0_modify_done, i_sdram_waitrequest, i_sdram_readdatavalid
  );

  modport slave (
    input  o_fragment_key, o_cntl_s0_modify, o_sdram_read, o_sdram_write,
    output i_cntl_s0_modify_done, i_sdram_waitrequest, i_sdram_readdatavalid
  );
endinterface

// File: rtl/segment_controller.sv
// rtl/segment_controller.sv - programs one rule by read/modify/write of each key fragment
module segment_controller #(
  parameter int DATA_BITS = 10,
  parameter int FRAGMENTS = 5,
  parameter int FRAG_BITS = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_key,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  segment_controller_if.master bus
);
  localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
  localparam int ADDR_WID = FRAG_BITS + FRAG_WID;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_RD_REQ, S_RD_WAIT, S_SETTLE,
    S_MODIFY, S_WR_REQ, S_NEXT, S_DONE, S_ABORT
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_key;
  logic [FRAG_BITS-1:0] r_f;
  logic [CNT_W-1:0]     r_cnt;
  logic [ADDR_WID-1:0]  r_frag_key;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_read;
  logic                 r_write;
  logic                 r_modify;

  logic [FRAG_BITS-1:0] w_next_f;
  logic [FRAG_WID-1:0]  w_next_slice;
  logic                 w_last;

  assign w_next_f     = r_f + 1'b1;
  assign w_next_slice = r_key[FRAG_WID * int'(w_next_f) +: FRAG_WID];
  assign w_last       = (r_f == FRAG_BITS'(FRAGMENTS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_f        <= '0;
      r_cnt      <= '0;
      r_frag_key <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_modify   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_key      <= i_key;
            r_f        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_frag_key <= {FRAG_BITS'(0), i_key[FRAG_WID-1:0]};
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_read  <= 1'b1;
          r_state <= S_RD_REQ;
        end
        S_RD_REQ: begin
          if (!bus.i_sdram_waitrequest) begin
            r_read  <= 1'b0;
            r_cnt   <= '0;
            // data may already be valid in the accept cycle
            r_state <= bus.i_sdram_readdatavalid ? S_SETTLE : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (bus.i_sdram_readdatavalid) begin
            r_state <= S_SETTLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_state <= S_ABORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          r_modify <= 1'b1;
          r_state  <= S_MODIFY;
        end
        S_MODIFY: begin
          if (bus.i_cntl_s0_modify_done) begin
            r_modify <= 1'b0;
            r_write  <= 1'b1;
            r_state  <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!bus.i_sdram_waitrequest) begin
            r_write <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_f        <= w_next_f;
            r_frag_key <= {w_next_f, w_next_slice};
            r_state    <= S_ADDR;
          end
        end
        S_DONE, S_ABORT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_error              = r_error;
  assign bus.o_fragment_key   = r_frag_key;
  assign bus.o_cntl_s0_modify = r_modify;
  assign bus.o_sdram_read     = r_read;
  assign bus.o_sdram_write    = r_write;
endmodule

// File: tb/tb_segment_controller.sv
// tb/tb_segment_controller.sv - scoreboard bench with SDRAM/datapath responder
module tb_segment_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [9:0] i_key;
  logic       o_busy, o_done, o_error;

  segment_controller_if #(.ADDR_WID(5)) bus ();

  segment_controller dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_key   (i_key),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_error (o_error),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_reads, n_writes, n_done, n_err;
  int cfg_wait, cfg_mod_wait, cfg_same, cfg_drop, cfg_stray;
  int wcnt, mcnt, rd_len, wr_len, rd_acc_cyc;
  logic rd_pend, prev_rd, prev_wr, prev_mod;
  logic wr_next, rdv_next, mdone_next;
  logic [4:0] last_rd_key;
  logic [4:0] sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rule(input logic [9:0] key);
    logic [9:0] k;
    k = key;
    for (int f = 0; f < 5; f++) sb.push_back({3'(f), k[2*f +: 2]});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0; prev_wr = 1'b0; prev_mod = 1'b0;
      rd_len = 0; wr_len = 0; wcnt = 0; mcnt = 0; rd_pend = 1'b0;
      wr_next = 1'b0; rdv_next = 1'b0; mdone_next = 1'b0;
    end else begin
      if (bus.o_sdram_read && bus.o_sdram_write) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (bus.o_sdram_read) begin
        if (!prev_rd) begin
          n_reads++;
          if (sb.size() == 0) check("scoreboard_underflow", 32'd0, 32'd1);
          else check("read_frag_key", 32'(bus.o_fragment_key), 32'(sb.pop_front()));
          last_rd_key = bus.o_fragment_key;
        end
        rd_len++;
      end else if (prev_rd) begin
        check("read_strobe_len", rd_len, cfg_wait + 1);
        rd_len = 0;
      end
      if (bus.o_sdram_write) begin
        if (!prev_wr) begin
          n_writes++;
          check("write_frag_key", 32'(bus.o_fragment_key), 32'(last_rd_key));
        end
        wr_len++;
      end else if (prev_wr) begin
        check("write_strobe_len", wr_len, cfg_wait + 1);
        wr_len = 0;
      end
      if (bus.o_cntl_s0_modify && !prev_mod)
        check("modify_latency", cyc - rd_acc_cyc, (cfg_same != 0) ? 2 : 3);
      if (o_done) n_done++;
      if (o_error) begin
        n_err++;
        check("timeout_len", cyc - rd_acc_cyc, 256);
      end
      prev_rd = bus.o_sdram_read;
      prev_wr = bus.o_sdram_write;
      prev_mod = bus.o_cntl_s0_modify;

      wr_next = 1'b0; rdv_next = 1'b0; mdone_next = 1'b0;
      if (rd_pend) begin
        rdv_next = 1'b1;
        rd_pend = 1'b0;
      end
      if (bus.o_sdram_read || bus.o_sdram_write) begin
        if (wcnt < cfg_wait) begin
          wr_next = 1'b1;
          wcnt++;
        end else begin
          wcnt = 0;
          if (bus.o_sdram_read) begin
            rd_acc_cyc = cyc;
            if (int'(bus.o_fragment_key[4:2]) != cfg_drop) begin
              if (cfg_same != 0) rdv_next = 1'b1;
              else rd_pend = 1'b1;
            end
          end
        end
      end else begin
        wcnt = 0;
      end
      if (bus.o_cntl_s0_modify) begin
        if (mcnt < cfg_mod_wait) mcnt++;
        else begin
          mdone_next = 1'b1;
          mcnt = 0;
        end
      end
    end
    bus.i_sdram_waitrequest   = wr_next;
    bus.i_sdram_readdatavalid = rdv_next | (cfg_stray != 0);
    bus.i_cntl_s0_modify_done = mdone_next | (cfg_stray != 0);
  end

  task automatic clear_counts();
    n_reads = 0; n_writes = 0; n_done = 0; n_err = 0;
  endtask

  task automatic start_rule(input logic [9:0] key);
    @(negedge clk);
    clear_counts();
    push_rule(key);
    i_key = key;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int i;
    i = 0;
    while (n_done == 0 && n_err == 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("end_within_bound", 32'(i < bound), 32'd1);
    repeat (3) @(negedge clk);
    check("busy_low_after", 32'(o_busy), 32'd0);
  endtask

  task automatic expect_counts(input string tag, input int r, input int w, input int d, input int e);
    check({tag, "_reads"}, r == n_reads, 1);
    check({tag, "_writes"}, w == n_writes, 1);
    check({tag, "_done"}, n_done, d);
    check({tag, "_error"}, n_err, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          32'({o_busy, o_done, o_error, bus.o_cntl_s0_modify, bus.o_sdram_read, bus.o_sdram_write}),
          32'd0);
    check({tag, "_frag_key"}, 32'(bus.o_fragment_key), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset = 1'b0; i_start = 1'b0; i_key = '0;
    cfg_wait = 0; cfg_mod_wait = 0; cfg_same = 0; cfg_drop = 7; cfg_stray = 0;
    rd_acc_cyc = 0; last_rd_key = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Zero-wait rule, start presented together with reset release
    push_rule(10'b11_10_01_00_11);
    i_key = 10'b11_10_01_00_11;
    i_start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("first_edge_accept", 32'(o_busy), 32'd1);
    wait_end(200);
    expect_counts("zero_wait", 5, 5, 1, 0);
    check("zero_wait_sb_empty", sb.size(), 0);

    // Three waitrequest cycles on every command
    cfg_wait = 3;
    start_rule(10'b01_11_00_10_01);
    wait_end(400);
    expect_counts("waitreq", 5, 5, 1, 0);
    check("waitreq_sb_empty", sb.size(), 0);

    // Read data never arrives for fragment 2
    cfg_wait = 0; cfg_drop = 2;
    start_rule(10'b11_10_01_00_11);
    wait_end(600);
    expect_counts("timeout", 3, 2, 0, 1);
    check("timeout_sb_left", sb.size(), 2);
    sb.delete();
    cfg_drop = 7;

    // Restart during fragment 1 is ignored
    start_rule(10'b10_01_11_00_10);
    i = 0;
    while (bus.o_fragment_key[4:2] != 3'd1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("reach_frag1", 32'(i < 100), 32'd1);
    i_key = 10'b01_10_00_11_01;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_end(200);
    expect_counts("restart_ignored", 5, 5, 1, 0);
    check("restart_sb_empty", sb.size(), 0);

    // Read data valid in the accept cycle
    cfg_same = 1;
    start_rule(10'b00_11_10_01_11);
    wait_end(200);
    expect_counts("same_cycle", 5, 5, 1, 0);
    cfg_same = 0;

    // Reset in the middle of fragment 3 modify
    cfg_mod_wait = 5;
    start_rule(10'b11_10_01_00_11);
    i = 0;
    while (!(bus.o_cntl_s0_modify && bus.o_fragment_key[4:2] == 3'd3) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("reach_frag3_modify", 32'(i < 200), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("midop_reset");
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    cfg_mod_wait = 0;
    start_rule(10'b01_00_11_10_00);
    wait_end(200);
    expect_counts("after_reset", 5, 5, 1, 0);
    check("after_reset_sb_empty", sb.size(), 0);

    // Stray handshakes while idle
    clear_counts();
    cfg_stray = 1;
    repeat (3) @(negedge clk);
    cfg_stray = 0;
    repeat (2) @(negedge clk);
    check("stray_busy", 32'(o_busy), 32'd0);
    expect_counts("stray", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
